bcd_conv_scheduler: RTL and testbench

BCD_CONV_SCHEDULER -- requirements
Module: bcd_conv_scheduler

---
 rtl/bcd_conv_scheduler.sv | 182 ++++++++++++++++++
 tb/tb_bcd_conv_scheduler.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_conv_scheduler.sv
// Round-robin scheduler that shares one binary-to-BCD conversion engine
// among NREQ requesters. One request is in flight at a time. Operands above
// 9999 are rejected without touching the engine. An engine that never
// answers is cut off after TIMEOUT cycles.
module bcd_conv_scheduler #(
    parameter int NREQ    = 4,
    parameter int TIMEOUT = 15
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NREQ-1:0]           req_valid,
    input  logic [14*NREQ-1:0]        req_data,
    output logic [NREQ-1:0]           req_ready,
    output logic                      eng_start,
    output logic [13:0]               eng_bin,
    input  logic                      eng_done,
    input  logic [15:0]               eng_bcd,
    output logic                      rsp_valid,
    output logic [$clog2(NREQ)-1:0]   rsp_id,
    output logic [15:0]               rsp_bcd,
    output logic                      rsp_err,
    input  logic                      rsp_ready,
    output logic                      busy
);

    localparam int ID_W = $clog2(NREQ);
    localparam int TW   = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t            state_reg;
    state_t            state_next;
    logic [ID_W-1:0]   rr_ptr_reg;
    logic [ID_W-1:0]   id_reg;
    logic [13:0]       bin_reg;
    logic [15:0]       bcd_reg;
    logic              err_reg;
    logic [TW-1:0]     timer_reg;

    logic [13:0]       operand [NREQ];
    logic              grant_found;
    logic [ID_W-1:0]   grant_idx;
    logic [ID_W-1:0]   cand_idx;
    logic              accept;
    logic              out_of_range;
    logic              timeout_hit;

    // Split the flat operand bus into one 14-bit operand per requester.
    genvar gi;
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_operand
            assign operand[gi] = req_data[14*gi +: 14];
        end
    endgenerate

    // Round-robin search: the first valid requester at or after rr_ptr, wrapping.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand_idx    = '0;
        for (int i = 0; i < NREQ; i++) begin
            cand_idx = ID_W'((int'(rr_ptr_reg) + i) % NREQ);
            if (!grant_found && req_valid[cand_idx]) begin
                grant_found = 1'b1;
                grant_idx   = cand_idx;
            end
        end
    end

    assign accept       = (state_reg == IDLE) && grant_found;
    assign out_of_range = (operand[grant_idx] > 14'd9999);
    // The counter starts at 0 on the first WAIT cycle, so TIMEOUT-1 marks the last allowed cycle.
    assign timeout_hit  = (timer_reg == TW'(TIMEOUT - 1));

    // Next-state logic and the handshake outputs, which are decoded from state.
    always_comb begin
        state_next = state_reg;
        req_ready  = '0;
        eng_start  = 1'b0;
        rsp_valid  = 1'b0;
        busy       = 1'b0;
        case (state_reg)
            IDLE: begin
                if (grant_found) begin
                    req_ready[grant_idx] = 1'b1;
                    state_next = out_of_range ? RESP : ISSUE;
                end
            end
            ISSUE: begin
                eng_start  = 1'b1;
                busy       = 1'b1;
                state_next = WAIT;
            end
            WAIT: begin
                busy = 1'b1;
                if (eng_done || timeout_hit) begin
                    state_next = RESP;
                end
            end
            RESP: begin
                rsp_valid = 1'b1;
                busy      = 1'b1;
                if (rsp_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
        // Keep every handshake output quiet while reset is held.
        if (rst) begin
            req_ready = '0;
            eng_start = 1'b0;
            rsp_valid = 1'b0;
            busy      = 1'b0;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Datapath: latch the request, time the engine, capture the result, advance the pointer.
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr_reg <= '0;
            id_reg     <= '0;
            bin_reg    <= '0;
            bcd_reg    <= '0;
            err_reg    <= 1'b0;
            timer_reg  <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (accept) begin
                        bin_reg <= operand[grant_idx];
                        id_reg  <= grant_idx;
                        if (out_of_range) begin
                            err_reg <= 1'b1;
                            bcd_reg <= 16'h0000;
                        end
                    end
                end
                ISSUE: begin
                    timer_reg <= '0;
                end
                WAIT: begin
                    timer_reg <= timer_reg + 1'b1;
                    // A result on the timeout cycle still counts as a success.
                    if (eng_done) begin
                        bcd_reg <= eng_bcd;
                        err_reg <= 1'b0;
                    end else if (timeout_hit) begin
                        bcd_reg <= 16'hFFFF;
                        err_reg <= 1'b1;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rr_ptr_reg <= (id_reg == ID_W'(NREQ - 1)) ? '0 : id_reg + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign eng_bin = bin_reg;
    assign rsp_id  = id_reg;
    assign rsp_bcd = bcd_reg;
    assign rsp_err = err_reg;

endmodule

// File: tb/tb_bcd_conv_scheduler.sv
// Directed bench for bcd_conv_scheduler with a behavioural conversion engine.
module tb_bcd_conv_scheduler;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req_valid;
    logic [13:0] d0, d1, d2, d3;
    logic [55:0] req_data;
    logic [3:0]  req_ready;
    logic        eng_start;
    logic [13:0] eng_bin;
    logic        eng_done;
    logic [15:0] eng_bcd;
    logic        rsp_valid;
    logic [1:0]  rsp_id;
    logic [15:0] rsp_bcd;
    logic        rsp_err;
    logic        rsp_ready;
    logic        busy;

    int errors = 0;
    int checks = 0;

    // Engine model controls
    int          eng_lat = 4;
    bit          eng_en  = 1'b1;
    int          inject_req = 0;
    int          inject_ack = 0;
    int          cnt = 0;
    logic [13:0] bin_cap = '0;
    logic [13:0] start_bin;

    assign req_data = {d3, d2, d1, d0};

    always #5 clk = ~clk;

    bcd_conv_scheduler #(.NREQ(4), .TIMEOUT(15)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .eng_start (eng_start),
        .eng_bin   (eng_bin),
        .eng_done  (eng_done),
        .eng_bcd   (eng_bcd),
        .rsp_valid (rsp_valid),
        .rsp_id    (rsp_id),
        .rsp_bcd   (rsp_bcd),
        .rsp_err   (rsp_err),
        .rsp_ready (rsp_ready),
        .busy      (busy)
    );

    function automatic logic [15:0] to_bcd(input logic [13:0] b);
        int v;
        v = int'(b);
        return {4'((v / 1000) % 10), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    // Engine: eng_done L cycles after a seen eng_start, or one injected stray pulse.
    always @(negedge clk) begin
        eng_done = 1'b0;
        if (inject_req != inject_ack) begin
            inject_ack = inject_req;
            eng_done   = 1'b1;
            eng_bcd    = 16'hBEEF;
        end else if (cnt > 0) begin
            cnt = cnt - 1;
            if (cnt == 0) begin
                eng_done = 1'b1;
                eng_bcd  = to_bcd(bin_cap);
            end
        end
        if (eng_start && eng_en) begin
            cnt     = eng_lat;
            bin_cap = eng_bin;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Counts cycles after acceptance (n=1 is the cycle after) until rsp_valid, bounded.
    task automatic wait_rsp(input bit drop, output int n, output int starts);
        n = 0;
        starts = 0;
        do begin
            @(negedge clk);
            n++;
            if (n == 1 && drop) req_valid = '0;
            if (eng_start) begin
                starts++;
                start_bin = eng_bin;
            end
        end while (!rsp_valid && n < 60);
        chk("rsp_arrived", {31'd0, rsp_valid}, 32'd1);
        $display("rsp id=%0d bcd=%04h err=%0b after %0d cycles, %0d starts", rsp_id, rsp_bcd, rsp_err, n, starts);
    endtask

    int n, starts, ng, nr, cyc, k;
    logic [3:0]  gr   [5];
    logic [1:0]  rid  [8];
    logic [15:0] rbcd [8];
    logic        rerr [8];

    initial begin
        rst = 1'b1; req_valid = 4'hF; d0 = '0; d1 = '0; d2 = '0; d3 = '0;
        rsp_ready = 1'b1; eng_done = 1'b0; eng_bcd = '0; start_bin = '0;
        repeat (2) @(negedge clk);

        // Reset state, with requests pending while reset is held
        chk("rst_req_ready", {28'd0, req_ready}, 32'h0);
        chk("rst_busy",      {31'd0, busy},      32'h0);
        chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'h0);
        chk("rst_eng_start", {31'd0, eng_start}, 32'h0);
        chk("rst_eng_bin",   {18'd0, eng_bin},   32'h0);
        chk("rst_rsp_bcd",   {16'd0, rsp_bcd},   32'h0);
        chk("rst_rsp_err",   {31'd0, rsp_err},   32'h0);
        chk("rst_rsp_id",    {30'd0, rsp_id},    32'h0);

        // Single request: requester 0, 1234, L=4
        rst = 1'b0; req_valid = 4'b0001; d0 = 14'd1234;
        #1;
        chk("t1_grant", {28'd0, req_ready}, 32'b0001);
        wait_rsp(1'b1, n, starts);
        chk("t1_latency", n, 6);
        chk("t1_starts",  starts, 1);
        chk("t1_eng_bin", {18'd0, start_bin}, 32'd1234);
        chk("t1_id",  {30'd0, rsp_id},  32'd0);
        chk("t1_bcd", {16'd0, rsp_bcd}, 32'h1234);
        chk("t1_err", {31'd0, rsp_err}, 32'd0);

        // Re-reset so the pointer restarts at 0, then four continuous requesters
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0; d0 = 14'd0; d1 = 14'd9; d2 = 14'd10; d3 = 14'd9999; req_valid = 4'hF;
        ng = 0; nr = 0; cyc = 0;
        while (ng < 5 && cyc < 200) begin
            #1;
            if (rsp_valid && nr < 8) begin
                rid[nr] = rsp_id; rbcd[nr] = rsp_bcd; rerr[nr] = rsp_err;
                $display("rr rsp id=%0d bcd=%04h err=%0b", rsp_id, rsp_bcd, rsp_err);
                nr++;
            end
            if (req_ready != 4'b0000) begin
                gr[ng] = req_ready;
                $display("rr grant %04b", req_ready);
                ng++;
            end
            if (ng < 5) begin
                @(negedge clk);
                cyc++;
            end
        end
        chk("rr_grant_count", ng, 5);
        chk("rr_rsp_count",   nr, 4);
        chk("rr_g0", {28'd0, gr[0]}, 32'b0001);
        chk("rr_g1", {28'd0, gr[1]}, 32'b0010);
        chk("rr_g2", {28'd0, gr[2]}, 32'b0100);
        chk("rr_g3", {28'd0, gr[3]}, 32'b1000);
        chk("rr_g4", {28'd0, gr[4]}, 32'b0001);
        chk("rr_id0", {30'd0, rid[0]}, 32'd0);
        chk("rr_id1", {30'd0, rid[1]}, 32'd1);
        chk("rr_id2", {30'd0, rid[2]}, 32'd2);
        chk("rr_id3", {30'd0, rid[3]}, 32'd3);
        chk("rr_bcd0", {16'd0, rbcd[0]}, 32'h0000);
        chk("rr_bcd1", {16'd0, rbcd[1]}, 32'h0009);
        chk("rr_bcd2", {16'd0, rbcd[2]}, 32'h0010);
        chk("rr_bcd3", {16'd0, rbcd[3]}, 32'h9999);
        chk("rr_err3", {31'd0, rerr[3]}, 32'd0);
        @(negedge clk);
        req_valid = '0;
        k = 0;
        while (busy && k < 60) begin
            @(negedge clk);
            k++;
        end
        chk("rr_drain", {31'd0, busy}, 32'd0);

        // Out-of-range operand from requester 2 (pointer is now at 1)
        req_valid = 4'b0100; d2 = 14'd10000;
        #1;
        chk("oor_grant", {28'd0, req_ready}, 32'b0100);
        wait_rsp(1'b1, n, starts);
        chk("oor_latency", n, 1);
        chk("oor_starts",  starts, 0);
        chk("oor_id",  {30'd0, rsp_id},  32'd2);
        chk("oor_err", {31'd0, rsp_err}, 32'd1);
        chk("oor_bcd", {16'd0, rsp_bcd}, 32'h0000);

        // Engine timeout on requester 3
        @(negedge clk);
        eng_en = 1'b0; req_valid = 4'b1000; d3 = 14'd42;
        #1;
        chk("to_grant", {28'd0, req_ready}, 32'b1000);
        wait_rsp(1'b1, n, starts);
        chk("to_latency", n, 17);
        chk("to_starts",  starts, 1);
        chk("to_id",  {30'd0, rsp_id},  32'd3);
        chk("to_err", {31'd0, rsp_err}, 32'd1);
        chk("to_bcd", {16'd0, rsp_bcd}, 32'hFFFF);
        inject_req++;
        repeat (2) begin
            @(negedge clk);
            chk("late_done_busy", {31'd0, busy},      32'd0);
            chk("late_done_rsp",  {31'd0, rsp_valid}, 32'd0);
        end
        eng_en = 1'b1; req_valid = 4'b0001; d0 = 14'd7;
        #1;
        chk("after_to_grant", {28'd0, req_ready}, 32'b0001);
        wait_rsp(1'b1, n, starts);
        chk("after_to_latency", n, 6);
        chk("after_to_bcd", {16'd0, rsp_bcd}, 32'h0007);
        chk("after_to_err", {31'd0, rsp_err}, 32'd0);

        // Backpressure: rsp_ready low for 5 cycles on requester 1
        @(negedge clk);
        rsp_ready = 1'b0; req_valid = 4'b0010; d1 = 14'd5678;
        #1;
        chk("bp_grant", {28'd0, req_ready}, 32'b0010);
        wait_rsp(1'b1, n, starts);
        chk("bp_latency", n, 6);
        req_valid = 4'hF;
        repeat (5) begin
            @(negedge clk);
            chk("bp_valid",     {31'd0, rsp_valid}, 32'd1);
            chk("bp_id",        {30'd0, rsp_id},    32'd1);
            chk("bp_bcd",       {16'd0, rsp_bcd},   32'h5678);
            chk("bp_err",       {31'd0, rsp_err},   32'd0);
            chk("bp_req_ready", {28'd0, req_ready}, 32'h0);
            chk("bp_eng_start", {31'd0, eng_start}, 32'd0);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        #1;
        chk("bp_idle",     {31'd0, busy},      32'd0);
        chk("bp_rr_grant", {28'd0, req_ready}, 32'b0100);
        req_valid = '0;

        // Reset during WAIT; the engine answers later and must be ignored
        @(negedge clk);
        eng_lat = 8; req_valid = 4'b0100; d2 = 14'd4321;
        @(negedge clk);
        req_valid = '0;
        @(negedge clk);
        chk("rw_in_wait", {31'd0, busy}, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        chk("rw_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("rw_busy",      {31'd0, busy},      32'd0);
        chk("rw_eng_bin",   {18'd0, eng_bin},   32'd0);
        chk("rw_rsp_bcd",   {16'd0, rsp_bcd},   32'd0);
        chk("rw_rsp_err",   {31'd0, rsp_err},   32'd0);
        chk("rw_rsp_id",    {30'd0, rsp_id},    32'd0);
        chk("rw_eng_start", {31'd0, eng_start}, 32'd0);
        rst = 1'b0;
        k = 0;
        repeat (12) begin
            @(negedge clk);
            if (rsp_valid || busy) k++;
        end
        chk("rw_no_response", k, 0);
        req_valid = 4'hF;
        #1;
        chk("rw_next_grant", {28'd0, req_ready}, 32'b0001);
        req_valid = '0;
        @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
